// File: rtl/mprj_io_ctrl_if.sv
// Serial configuration channel between housekeeping (master) and the pad control block (slave).
// Carries the config bit stream, strobe/load qualifiers and the status/readback return path.
interface mprj_io_ctrl_if;
  logic ser_data_in;
  logic ser_strobe;
  logic ser_load;
  logic err_clr;
  logic ser_data_out;
  logic cfg_busy;
  logic cfg_done;
  logic cfg_err;

  modport master (
    output ser_data_in, ser_strobe, ser_load, err_clr,
    input  ser_data_out, cfg_busy, cfg_done, cfg_err
  );

  modport slave (
    input  ser_data_in, ser_strobe, ser_load, err_clr,
    output ser_data_out, cfg_busy, cfg_done, cfg_err
  );
endinterface

// File: rtl/mprj_io_ctrl.sv
// Per-pad GPIO control: serial shadow chain, atomic frame commit, mgmt/user pad muxing. Optional MPRJ_IO_CTRL_READBACK_EN.
// Latency: new config on pads one cycle after ser_load; no backpressure, the sender must deliver exactly one full frame.
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module mprj_io_ctrl #(
  parameter int                  TOTAL_PADS = `MPRJ_IO_PADS,
  parameter int                  CFG_BITS   = 13,
  parameter logic [CFG_BITS-1:0] RESET_CFG  = 13'h0403
) (
  input  logic                    clock,
  input  logic                    resetb,
  mprj_io_ctrl_if.slave           cfg,
  input  logic [TOTAL_PADS-1:0]   mgmt_io_out,
  input  logic [TOTAL_PADS-1:0]   mgmt_oeb,
  input  logic [TOTAL_PADS-1:0]   user_io_out,
  input  logic [TOTAL_PADS-1:0]   user_oeb,
  input  logic [TOTAL_PADS-1:0]   io_in,
  output logic [TOTAL_PADS-1:0]   mgmt_io_in,
  output logic [TOTAL_PADS-1:0]   user_io_in,
  output logic [TOTAL_PADS-1:0]   io_out,
  output logic [TOTAL_PADS-1:0]   oeb,
  output logic [TOTAL_PADS-1:0]   inp_dis,
  output logic [TOTAL_PADS-1:0]   ib_mode_sel,
  output logic [TOTAL_PADS-1:0]   vtrip_sel,
  output logic [TOTAL_PADS-1:0]   slow_sel,
  output logic [TOTAL_PADS-1:0]   holdover,
  output logic [TOTAL_PADS-1:0]   analog_en,
  output logic [TOTAL_PADS-1:0]   analog_sel,
  output logic [TOTAL_PADS-1:0]   analog_pol,
  output logic [3*TOTAL_PADS-1:0] dm
);

  localparam int N  = TOTAL_PADS * CFG_BITS;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N + 1);

  logic [N-1:0]  shadow;
  logic [N-1:0]  active;
  logic [CW-1:0] cnt;
  logic          done_q;
  logic          err_q;
  logic          full;

  assign full = (cnt == CNT_FULL);

  // A load always wins over a same-cycle strobe; an error set wins over err_clr.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      shadow <= {TOTAL_PADS{RESET_CFG}};
      active <= {TOTAL_PADS{RESET_CFG}};
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cfg.err_clr) err_q <= 1'b0;
      if (cfg.ser_load) begin
        cnt <= '0;
        if (full) begin
          active <= shadow;
          done_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end else if (cfg.ser_strobe) begin
        shadow <= {shadow[N-2:0], cfg.ser_data_in};
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef MPRJ_IO_CTRL_READBACK_EN
  logic sdo_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sdo_q <= 1'b0;
    end else if (cfg.ser_strobe && !cfg.ser_load) begin
      sdo_q <= shadow[N-1];
    end
  end

  assign cfg.ser_data_out = sdo_q;
`else
  assign cfg.ser_data_out = 1'b0;
`endif

  assign cfg.cfg_busy = (cnt != '0);
  assign cfg.cfg_done = done_q;
  assign cfg.cfg_err  = err_q;

  for (genvar p = 0; p < TOTAL_PADS; p++) begin : g_pad
    logic [CFG_BITS-1:0] w;
    assign w = active[p*CFG_BITS +: CFG_BITS];

    assign io_out[p]      = w[0] ? mgmt_io_out[p] : user_io_out[p];
    assign oeb[p]         = w[1] | (w[0] ? mgmt_oeb[p] : user_oeb[p]);
    assign mgmt_io_in[p]  = io_in[p] &  w[0] & ~w[3];
    assign user_io_in[p]  = io_in[p] & ~w[0] & ~w[3];
    assign holdover[p]    = w[2];
    assign inp_dis[p]     = w[3];
    assign ib_mode_sel[p] = w[4];
    assign analog_en[p]   = w[5];
    assign analog_sel[p]  = w[6];
    assign analog_pol[p]  = w[7];
    assign slow_sel[p]    = w[8];
    assign vtrip_sel[p]   = w[9];
    assign dm[3*p +: 3]   = w[12:10];
  end

endmodule

// File: tb/tb_mprj_io_ctrl.sv
// Directed bench for mprj_io_ctrl: reset state, frame commit, short/long frames, strobe+load collisions,
// mid-frame reset and (with MPRJ_IO_CTRL_READBACK_EN) previous-frame readback.
module tb_mprj_io_ctrl;
  localparam int P = 38;
  localparam int N = 494;

  localparam logic [P-1:0] MGMT_OUT = 38'h2A_AAAA_AAAA;
  localparam logic [P-1:0] MGMT_OEB = 38'h00_0000_0000;
  localparam logic [P-1:0] USER_OUT = 38'h0F_0F0F_0F0F;
  localparam logic [P-1:0] USER_OEB = 38'h3F_0000_FFFF;
  localparam logic [P-1:0] IO_IN    = 38'h2A_AAAA_AAAA;
  localparam logic [P-1:0] ONES     = '1;
  localparam logic [P-1:0] ZEROS    = '0;

  logic clock = 1'b0;
  logic resetb;
  always #5 clock = ~clock;

  logic [P-1:0]   mgmt_io_out, mgmt_oeb, user_io_out, user_oeb, io_in;
  logic [P-1:0]   mgmt_io_in, user_io_in, io_out, oeb, inp_dis, ib_mode_sel, vtrip_sel;
  logic [P-1:0]   slow_sel, holdover, analog_en, analog_sel, analog_pol;
  logic [3*P-1:0] dm;
  logic [3*P-1:0] dm_001, dm_110, dm_011;

  int checks = 0;
  int errors = 0;

  mprj_io_ctrl_if hk();

  mprj_io_ctrl dut (
    .clock       (clock),
    .resetb      (resetb),
    .cfg         (hk),
    .mgmt_io_out (mgmt_io_out),
    .mgmt_oeb    (mgmt_oeb),
    .user_io_out (user_io_out),
    .user_oeb    (user_oeb),
    .io_in       (io_in),
    .mgmt_io_in  (mgmt_io_in),
    .user_io_in  (user_io_in),
    .io_out      (io_out),
    .oeb         (oeb),
    .inp_dis     (inp_dis),
    .ib_mode_sel (ib_mode_sel),
    .vtrip_sel   (vtrip_sel),
    .slow_sel    (slow_sel),
    .holdover    (holdover),
    .analog_en   (analog_en),
    .analog_sel  (analog_sel),
    .analog_pol  (analog_pol),
    .dm          (dm)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bit k of the stream is word[12 - k%13], so every 13 bits deliver one pad word MSB first.
  task automatic send_bits(input int nbits, input logic [12:0] word);
    for (int k = 0; k < nbits; k++) begin
      hk.ser_data_in = word[12 - (k % 13)];
      hk.ser_strobe  = 1'b1;
      tick();
    end
    hk.ser_strobe  = 1'b0;
    hk.ser_data_in = 1'b0;
  endtask

  task automatic pulse_err_clr();
    hk.err_clr = 1'b1;
    tick();
    hk.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    hk.ser_data_in = 1'b0; hk.ser_strobe = 1'b0; hk.ser_load = 1'b0; hk.err_clr = 1'b0;
    mgmt_io_out = MGMT_OUT; mgmt_oeb = MGMT_OEB;
    user_io_out = USER_OUT; user_oeb = USER_OEB; io_in = IO_IN;
    repeat (3) tick();
    resetb = 1'b1;
    tick();
    checks++; if (oeb !== ONES) begin errors++; $display("FAIL reset_oeb got %h exp %h", oeb, ONES); end
    checks++; if (dm !== dm_001) begin errors++; $display("FAIL reset_dm got %h exp %h", dm, dm_001); end
    checks++; if (inp_dis !== ZEROS) begin errors++; $display("FAIL reset_inp_dis got %h exp %h", inp_dis, ZEROS); end
    checks++; if (io_out !== MGMT_OUT) begin errors++; $display("FAIL reset_io_out got %h exp %h", io_out, MGMT_OUT); end
    checks++; if (mgmt_io_in !== IO_IN) begin errors++; $display("FAIL reset_mgmt_io_in got %h exp %h", mgmt_io_in, IO_IN); end
    checks++; if (user_io_in !== ZEROS) begin errors++; $display("FAIL reset_user_io_in got %h exp %h", user_io_in, ZEROS); end
    checks++; if (holdover !== ZEROS) begin errors++; $display("FAIL reset_holdover got %h exp %h", holdover, ZEROS); end
    checks++; if ({hk.cfg_err, hk.cfg_busy, hk.cfg_done, hk.ser_data_out} !== 4'b0000) begin
      errors++; $display("FAIL reset_status got %b exp 0000", {hk.cfg_err, hk.cfg_busy, hk.cfg_done, hk.ser_data_out});
    end
  endtask

  task automatic test_commit_user();
    send_bits(N, 13'h1800);
    checks++; if (hk.cfg_busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b exp 1", hk.cfg_busy); end
    checks++; if (io_out !== MGMT_OUT) begin errors++; $display("FAIL pre_load_io_out got %h exp %h", io_out, MGMT_OUT); end
    hk.ser_load = 1'b1;
    tick();
    hk.ser_load = 1'b0;
    checks++; if (hk.cfg_done !== 1'b1) begin errors++; $display("FAIL commit_done got %b exp 1", hk.cfg_done); end
    checks++; if (io_out !== USER_OUT) begin errors++; $display("FAIL commit_io_out got %h exp %h", io_out, USER_OUT); end
    checks++; if (oeb !== USER_OEB) begin errors++; $display("FAIL commit_oeb got %h exp %h", oeb, USER_OEB); end
    checks++; if (dm !== dm_110) begin errors++; $display("FAIL commit_dm got %h exp %h", dm, dm_110); end
    checks++; if (user_io_in !== IO_IN) begin errors++; $display("FAIL commit_user_io_in got %h exp %h", user_io_in, IO_IN); end
    checks++; if (mgmt_io_in !== ZEROS) begin errors++; $display("FAIL commit_mgmt_io_in got %h exp %h", mgmt_io_in, ZEROS); end
    checks++; if (hk.cfg_busy !== 1'b0) begin errors++; $display("FAIL commit_busy got %b exp 0", hk.cfg_busy); end
    tick();
    checks++; if (hk.cfg_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b exp 0", hk.cfg_done); end
  endtask

  task automatic test_short_frame();
    send_bits(N - 1, 13'h0403);
    hk.ser_load = 1'b1;
    hk.err_clr  = 1'b1;
    tick();
    hk.ser_load = 1'b0;
    hk.err_clr  = 1'b0;
    checks++; if (hk.cfg_err !== 1'b1) begin errors++; $display("FAIL short_err_over_clr got %b exp 1", hk.cfg_err); end
    checks++; if (hk.cfg_done !== 1'b0) begin errors++; $display("FAIL short_done got %b exp 0", hk.cfg_done); end
    checks++; if (dm !== dm_110) begin errors++; $display("FAIL short_dm got %h exp %h", dm, dm_110); end
    checks++; if (io_out !== USER_OUT) begin errors++; $display("FAIL short_io_out got %h exp %h", io_out, USER_OUT); end
    checks++; if (hk.cfg_busy !== 1'b0) begin errors++; $display("FAIL short_busy got %b exp 0", hk.cfg_busy); end
    tick();
    checks++; if (hk.cfg_err !== 1'b1) begin errors++; $display("FAIL short_err_sticky got %b exp 1", hk.cfg_err); end
    pulse_err_clr();
    checks++; if (hk.cfg_err !== 1'b0) begin errors++; $display("FAIL err_clr got %b exp 0", hk.cfg_err); end
  endtask

  task automatic test_long_frame();
    send_bits(N + 1, 13'h1FFF);
    checks++; if (hk.cfg_busy !== 1'b1) begin errors++; $display("FAIL long_busy got %b exp 1", hk.cfg_busy); end
    hk.ser_load = 1'b1;
    tick();
    hk.ser_load = 1'b0;
    checks++; if (hk.cfg_err !== 1'b1) begin errors++; $display("FAIL long_err got %b exp 1", hk.cfg_err); end
    checks++; if (hk.cfg_done !== 1'b0) begin errors++; $display("FAIL long_done got %b exp 0", hk.cfg_done); end
    checks++; if (dm !== dm_110) begin errors++; $display("FAIL long_dm got %h exp %h", dm, dm_110); end
    checks++; if (oeb !== USER_OEB) begin errors++; $display("FAIL long_oeb got %h exp %h", oeb, USER_OEB); end
    checks++; if (hk.cfg_busy !== 1'b0) begin errors++; $display("FAIL long_busy_after got %b exp 0", hk.cfg_busy); end
    pulse_err_clr();
  endtask

  task automatic test_back_to_back_strobe_load();
    send_bits(N, 13'h0C21);
    hk.ser_data_in = 1'b1;
    hk.ser_strobe  = 1'b1;
    hk.ser_load    = 1'b1;
    tick();
    hk.ser_strobe = 1'b0;
    hk.ser_load   = 1'b0;
    checks++; if (hk.cfg_done !== 1'b1) begin errors++; $display("FAIL coll_full_done got %b exp 1", hk.cfg_done); end
    checks++; if (io_out !== MGMT_OUT) begin errors++; $display("FAIL coll_full_io_out got %h exp %h", io_out, MGMT_OUT); end
    checks++; if (oeb !== MGMT_OEB) begin errors++; $display("FAIL coll_full_oeb got %h exp %h", oeb, MGMT_OEB); end
    checks++; if (analog_en !== ONES) begin errors++; $display("FAIL coll_full_analog_en got %h exp %h", analog_en, ONES); end
    checks++; if (dm !== dm_011) begin errors++; $display("FAIL coll_full_dm got %h exp %h", dm, dm_011); end
    checks++; if (mgmt_io_in !== IO_IN) begin errors++; $display("FAIL coll_full_mgmt_in got %h exp %h", mgmt_io_in, IO_IN); end
    checks++; if (hk.cfg_busy !== 1'b0) begin errors++; $display("FAIL coll_full_strobe_dropped got %b exp 0", hk.cfg_busy); end

    send_bits(N - 1, 13'h1800);
    hk.ser_strobe = 1'b1;
    hk.ser_load   = 1'b1;
    tick();
    hk.ser_strobe = 1'b0;
    hk.ser_load   = 1'b0;
    checks++; if (hk.cfg_err !== 1'b1) begin errors++; $display("FAIL coll_short_err got %b exp 1", hk.cfg_err); end
    checks++; if (hk.cfg_done !== 1'b0) begin errors++; $display("FAIL coll_short_done got %b exp 0", hk.cfg_done); end
    checks++; if (dm !== dm_011) begin errors++; $display("FAIL coll_short_dm got %h exp %h", dm, dm_011); end
    checks++; if (hk.cfg_busy !== 1'b0) begin errors++; $display("FAIL coll_short_busy got %b exp 0", hk.cfg_busy); end
    pulse_err_clr();
  endtask

  task automatic test_reset_mid_frame();
    send_bits(N, 13'h1800);
    hk.ser_load = 1'b1;
    tick();
    hk.ser_load = 1'b0;
    send_bits(200, 13'h1FFF);
    resetb = 1'b0;
    #2;
    checks++; if (oeb !== ONES) begin errors++; $display("FAIL rst_mid_oeb got %h exp %h", oeb, ONES); end
    checks++; if (dm !== dm_001) begin errors++; $display("FAIL rst_mid_dm got %h exp %h", dm, dm_001); end
    checks++; if (io_out !== MGMT_OUT) begin errors++; $display("FAIL rst_mid_io_out got %h exp %h", io_out, MGMT_OUT); end
    checks++; if (user_io_in !== ZEROS) begin errors++; $display("FAIL rst_mid_user_in got %h exp %h", user_io_in, ZEROS); end
    checks++; if (hk.cfg_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", hk.cfg_busy); end
    tick();
    resetb = 1'b1;
    tick();
    checks++; if ({hk.cfg_busy, hk.cfg_done, hk.cfg_err} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_status got %b exp 000", {hk.cfg_busy, hk.cfg_done, hk.cfg_err});
    end
  endtask

  task automatic test_readback();
    logic [N-1:0]   fa;
    logic [3*P-1:0] dm_exp;
    for (int i = 0; i < N; i++) fa[i] = 1'($urandom_range(0, 1));
    for (int k = 0; k < N; k++) begin
      hk.ser_data_in = fa[N-1-k];
      hk.ser_strobe  = 1'b1;
      tick();
    end
    hk.ser_strobe = 1'b0;
    hk.ser_load   = 1'b1;
    tick();
    hk.ser_load   = 1'b0;
    for (int p = 0; p < P; p++) dm_exp[3*p +: 3] = fa[p*13 + 10 +: 3];
    checks++; if (hk.cfg_done !== 1'b1) begin errors++; $display("FAIL rb_commit_done got %b exp 1", hk.cfg_done); end
    checks++; if (dm !== dm_exp) begin errors++; $display("FAIL rb_commit_dm got %h exp %h", dm, dm_exp); end
    for (int k = 0; k < N; k++) begin
      hk.ser_data_in = ~fa[N-1-k];
      hk.ser_strobe  = 1'b1;
      tick();
`ifdef MPRJ_IO_CTRL_READBACK_EN
      checks++; if (hk.ser_data_out !== fa[N-1-k]) begin
        errors++; $display("FAIL rb_bit_%0d got %b exp %b", k, hk.ser_data_out, fa[N-1-k]);
      end
`else
      checks++; if (hk.ser_data_out !== 1'b0) begin
        errors++; $display("FAIL rb_tied_%0d got %b exp 0", k, hk.ser_data_out);
      end
`endif
    end
    hk.ser_strobe = 1'b0;
    hk.ser_load   = 1'b1;
    tick();
    hk.ser_load   = 1'b0;
    checks++; if (hk.cfg_done !== 1'b1) begin errors++; $display("FAIL rb_second_done got %b exp 1", hk.cfg_done); end
  endtask

  initial begin
    dm_001 = {P{3'b001}};
    dm_110 = {P{3'b110}};
    dm_011 = {P{3'b011}};
    test_reset();
    test_commit_user();
    test_short_frame();
    test_long_frame();
    test_back_to_back_strobe_load();
    test_reset_mid_frame();
    test_readback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mprj_io_ctrl.md
Name: mprj_io_ctrl

Overview:
- Per-pad control block driving the user-project GPIO pad array (io_out, oeb, inp_dis, dm, analog/slew/trip selects).
- Receives pad configuration over a single-clock serial chain from housekeeping and holds it in a shadow shift register.
- Commits a complete frame atomically to the active configuration.
- Muxes each pad between the management and user-project sources according to its active configuration.

Parameters:
- TOTAL_PADS, `MPRJ_IO_PADS (38): number of pads controlled.
- CFG_BITS, 13: configuration bits per pad.
- RESET_CFG, 13'h0403: per-pad active and shadow value at reset (mgmt_ena=1, out_dis=1, dm=3'b001).

Ports:
- clock  in  1  system clock.
- resetb  in  1  asynchronous active-low reset.
- ser_data_in  in  1  serial config bit.
- ser_strobe  in  1  shift ser_data_in into the chain this cycle.
- ser_load  in  1  commit the shadow frame this cycle.
- err_clr  in  1  clear cfg_err.
- ser_data_out  out  1  chain tail (see Optional Feature).
- cfg_busy  out  1  frame partially or fully shifted, not yet loaded.
- cfg_done  out  1  one-cycle pulse after a successful commit.
- cfg_err  out  1  sticky bad-frame flag.
- mgmt_io_out, mgmt_oeb  in  TOTAL_PADS  management-side pad drive.
- user_io_out, user_oeb  in  TOTAL_PADS  user-side pad drive.
- io_in  in  TOTAL_PADS  pad input from the pad array.
- mgmt_io_in, user_io_in  out  TOTAL_PADS  gated return paths.
- io_out, oeb, inp_dis, ib_mode_sel, vtrip_sel, slow_sel, holdover, analog_en, analog_sel, analog_pol  out  TOTAL_PADS  pad controls.
- dm  out  3*TOTAL_PADS  drive mode, 3 bits per pad.

Behaviour:
- Clock and reset (already decided): one clock, `clock`. Reset `resetb` is asynchronous, active-low.
- Per-pad word layout:
  - [0] mgmt_ena, [1] out_dis, [2] holdover, [3] inp_dis, [4] ib_mode_sel
  - [5] analog_en, [6] analog_sel, [7] analog_pol, [8] slow_sel, [9] vtrip_sel
  - [12:10] dm
- Frame: N = TOTAL_PADS*CFG_BITS bits (494 at default). Pad p uses shadow[p*CFG_BITS +: CFG_BITS].
- Shift: on ser_strobe, shadow <= {shadow[N-2:0], ser_data_in}. The sender sends pad TOTAL_PADS-1 first, MSB first.
- Bit counter cnt, width clog2(N+2), saturates at N+1. It defines four states:
  - IDLE: cnt==0.
  - SHIFTING: 0<cnt<N.
  - FULL: cnt==N.
  - OVERRUN: cnt>N.
- ser_load handling:
  - In FULL: active <= shadow at the next edge, cfg_done=1 for exactly one cycle after, cnt <= 0.
  - In any other state: no commit, cfg_err <= 1, cnt <= 0, shadow retained.
- ser_strobe and ser_load in the same cycle: the load is processed and the strobe is ignored (bit dropped, no shift).
- err_clr: cfg_err <= 0. A simultaneous error set wins over err_clr.
- cfg_busy = (cnt != 0).
- Pad outputs are combinational from active config and sources:
  - io_out = mgmt_ena ? mgmt_io_out : user_io_out
  - oeb = out_dis | (mgmt_ena ? mgmt_oeb : user_oeb)
  - mgmt_io_in = io_in & mgmt_ena & ~inp_dis
  - user_io_in = io_in & ~mgmt_ena & ~inp_dis
  - remaining pad controls come straight from the active bits.
- Latency: a new config drives the pads one cycle after the ser_load sample.
- Reset values:
  - active = shadow = RESET_CFG per pad; cnt=0; cfg_done=0; cfg_err=0; ser_data_out=0.
  - Hence oeb=1, inp_dis=0, dm=3'b001 on all pads.
  - Pads are in management mode; mgmt_io_in follows io_in, user_io_in=0.
- Reset mid-frame: partial frame discarded, active returns to RESET_CFG, no cfg_done.
- Strobes in OVERRUN keep shifting; the frame is already invalid and the next load flags an error.

Optional Feature:
- Macro: MPRJ_IO_CTRL_READBACK_EN.
- Defined: ser_data_out is registered shadow[N-1], updated on every shift. Since shadow equals active after a commit, shifting the next frame streams the previous configuration out for host verification.
- Undefined: ser_data_out is tied to 0 and no readback register is built. The port is always present.

Test Plan:
- Reset then idle: all oeb=1, dm=3'b001 per pad, cfg_err=0; io_in=38'h2A_AAAA_AAAA appears on mgmt_io_in; user_io_in=0.
- Exactly 494 strobes with every pad word 13'h1800 (user, dm=110), then ser_load:
  - cfg_done pulses once; next cycle io_out==user_io_out, oeb==user_oeb, dm=3'b110 per pad.
  - user_io_in==io_in, mgmt_io_in=0.
- 493 strobes then ser_load: cfg_err=1, no cfg_done, outputs unchanged. err_clr then clears cfg_err.
- 495 strobes then ser_load: cfg_err=1, active unchanged, cnt back to 0 (cfg_busy=0).
- Strobe and load in the same cycle at cnt==494: commit happens, strobe bit dropped, shadow unchanged. Repeat at cnt==493: error.
- resetb low at strobe 200: outputs return to RESET_CFG immediately, cfg_busy=0.
- With MPRJ_IO_CTRL_READBACK_EN: after committing frame A, shifting frame B returns A bit-exactly on ser_data_out.
